// File: rtl/wbledwalker_pkg.sv
// Shared constants and types for the Wishbone LED walker: register map,
// CTRL bit positions, mode/state encodings and the divider helper.
package wbledwalker_pkg;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_DIV  = 2'd1;
    localparam logic [1:0] ADDR_REP  = 2'd2;
    localparam logic [1:0] ADDR_LED  = 2'd3;

    localparam int CTRL_GO    = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_ABORT = 2;

    typedef enum logic { MODE_BOUNCE = 1'b0, MODE_WRAP = 1'b1 } mode_e;
    typedef enum logic { ST_IDLE = 1'b0, ST_WALK = 1'b1 } state_e;

    // A divider of 0 behaves like 1, so the terminal count never underflows.
    function automatic logic [31:0] period_m1(input logic [31:0] div);
        return (div == 32'd0) ? 32'd0 : div - 32'd1;
    endfunction

endpackage

// File: rtl/wbledwalker_tick.sv
// Step-period counter: emits a one-cycle step strobe every (period_m1+1)
// enabled clocks; a start clear restarts the period from zero.
module wbledwalker_tick (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] period_m1,
    output logic        step
);

    logic [31:0] count;

    assign step = enable && !clear && (count == period_m1);

    // Period counter, restarted on start and at every step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 32'd0;
        end else if (clear || step) begin
            count <= 32'd0;
        end else if (enable) begin
            count <= count + 32'd1;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/wbledwalker.sv
// Wishbone-controlled LED walker (bounce/wrap, programmable period and repeats).
// Optional macro WBLEDWALKER_ABORT_EN adds a CTRL abort and removes CTRL stalls.
module wbledwalker
    import wbledwalker_pkg::*;
#(
    parameter int          NLEDS       = 8,
    parameter logic [31:0] DEFAULT_DIV = 32'd50_000_000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [1:0]       i_wb_addr,
    input  logic [31:0]      i_wb_data,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic [31:0]      o_wb_data,
    output logic [NLEDS-1:0] o_led,
    output logic             o_int
);

    localparam int               PW        = $clog2(NLEDS);
    localparam logic [PW-1:0]    POS_LAST  = PW'(NLEDS - 1);
    localparam logic [PW-1:0]    POS_TURN  = PW'(NLEDS - 2);
    localparam logic [NLEDS-1:0] LED_FIRST = NLEDS'(1);

    state_e           state, state_n;
    mode_e            mode;
    logic [PW-1:0]    pos, pos_n;
    logic             dir_down, dir_down_n;
    logic [15:0]      rep_left, rep_left_n;
    logic [NLEDS-1:0] led, led_n;
    logic             irq, irq_n;
    logic             end_pass;
    logic [31:0]      period_sh;
    logic [31:0]      div_reg;
    logic [15:0]      rep_reg;
    logic             ack;
    logic [31:0]      rdata, rd_mux, ctrl_rd;
    logic             busy, accept, ctrl_wr, go, abort, step;

    assign busy    = (state == ST_WALK);
`ifdef WBLEDWALKER_ABORT_EN
    assign o_wb_stall = 1'b0;
`else
    assign o_wb_stall = busy && i_wb_we && (i_wb_addr == ADDR_CTRL);
`endif
    assign accept  = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign ctrl_wr = accept && i_wb_we && (i_wb_addr == ADDR_CTRL);
    assign go      = ctrl_wr && !busy && i_wb_data[CTRL_GO];
`ifdef WBLEDWALKER_ABORT_EN
    assign abort   = ctrl_wr && busy && i_wb_data[CTRL_ABORT];
`else
    assign abort   = 1'b0;
`endif

    wbledwalker_tick u_tick (
        .clk       (i_clk),
        .reset     (i_reset),
        .clear     (go),
        .enable    (busy),
        .period_m1 (period_sh),
        .step      (step)
    );

    // Walker next-state: start, abort, position advance and pass completion.
    always_comb begin
        state_n    = state;
        pos_n      = pos;
        dir_down_n = dir_down;
        rep_left_n = rep_left;
        led_n      = led;
        irq_n      = 1'b0;
        end_pass   = 1'b0;
        if (state == ST_IDLE) begin
            if (go) begin
                state_n    = ST_WALK;
                pos_n      = '0;
                dir_down_n = 1'b0;
                rep_left_n = rep_reg;
                led_n      = LED_FIRST;
            end else begin
                led_n      = '0;
            end
        end else if (abort) begin
            state_n    = ST_IDLE;
            pos_n      = '0;
            dir_down_n = 1'b0;
            rep_left_n = 16'd0;
            led_n      = '0;
        end else if (step) begin
            case (mode)
                MODE_WRAP: begin
                    if (pos == POS_LAST) end_pass = 1'b1;
                    else                 pos_n    = pos + PW'(1);
                end
                MODE_BOUNCE: begin
                    if (!dir_down) begin
                        if (pos == POS_LAST) begin
                            dir_down_n = 1'b1;
                            pos_n      = POS_TURN;
                        end else begin
                            pos_n      = pos + PW'(1);
                        end
                    end else if (pos == '0) begin
                        end_pass = 1'b1;
                    end else begin
                        pos_n    = pos - PW'(1);
                    end
                end
                default: end_pass = 1'b1;
            endcase
            if (end_pass) begin
                pos_n      = '0;
                dir_down_n = 1'b0;
                if (rep_left != 16'd0) begin
                    rep_left_n = rep_left - 16'd1;
                end else begin
                    state_n = ST_IDLE;
                    irq_n   = 1'b1;
                end
            end else begin
                rep_left_n = rep_left;
            end
            led_n = (state_n == ST_WALK) ? (LED_FIRST << pos_n) : '0;
        end else begin
            led_n = led;
        end
    end

    // Walker state registers; mode and period are shadowed only at GO.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            pos       <= '0;
            dir_down  <= 1'b0;
            rep_left  <= 16'd0;
            led       <= '0;
            irq       <= 1'b0;
            mode      <= MODE_BOUNCE;
            period_sh <= 32'd0;
        end else begin
            state    <= state_n;
            pos      <= pos_n;
            dir_down <= dir_down_n;
            rep_left <= rep_left_n;
            led      <= led_n;
            irq      <= irq_n;
            if (go) begin
                mode      <= mode_e'(i_wb_data[CTRL_MODE]);
                period_sh <= period_m1(div_reg);
            end
        end
    end

    // Read-back multiplexer.
    always_comb begin
        ctrl_rd = {rep_left, 3'd0, 5'(pos), 6'd0, mode, busy};
        case (i_wb_addr)
            ADDR_CTRL: rd_mux = ctrl_rd;
            ADDR_DIV:  rd_mux = div_reg;
            ADDR_REP:  rd_mux = {16'd0, rep_reg};
            ADDR_LED:  rd_mux = 32'(led);
            default:   rd_mux = 32'd0;
        endcase
    end

    // Bus registers: programmable DIV/REP, ack and registered read data.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ack     <= 1'b0;
            rdata   <= 32'd0;
            div_reg <= DEFAULT_DIV;
            rep_reg <= 16'd0;
        end else begin
            ack   <= accept;
            rdata <= (accept && !i_wb_we) ? rd_mux : 32'd0;
            if (accept && i_wb_we) begin
                case (i_wb_addr)
                    ADDR_DIV: div_reg <= i_wb_data;
                    ADDR_REP: rep_reg <= i_wb_data[15:0];
                    default:  div_reg <= div_reg;
                endcase
            end
        end
    end

    assign o_wb_ack  = ack;
    assign o_wb_data = rdata;
    assign o_led     = led;
    assign o_int     = irq;

endmodule

// File: tb/tb_wbledwalker.sv
// Scoreboard bench for wbledwalker: a 4-LED and a 2-LED instance share one bus,
// expected LED/interrupt traces and bus responses are queued at stimulus time.
module tb_wbledwalker;

    localparam logic [31:0] DDIV = 32'd1000;

    typedef struct { logic [31:0] led; logic irq; } trace_t;
    typedef struct { logic sel; logic is_rd; logic [31:0] data; } ack_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc4, cyc2, stb, we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        stall4, ack4, int4, stall2, ack2, int2;
    logic [31:0] data4, data2;
    logic [3:0]  led4;
    logic [1:0]  led2;

    trace_t tq4[$];
    trace_t tq2[$];
    ack_t   aq[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     st;

    always #5 clk = ~clk;

    wbledwalker #(.NLEDS(4), .DEFAULT_DIV(DDIV)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc4), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_stall(stall4), .o_wb_ack(ack4),
        .o_wb_data(data4), .o_led(led4), .o_int(int4));

    wbledwalker #(.NLEDS(2), .DEFAULT_DIV(DDIV)) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc2), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_stall(stall2), .o_wb_ack(ack2),
        .o_wb_data(data2), .o_led(led2), .o_int(int2));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void push_trace(input logic sel, input logic [31:0] led, input logic irq);
        trace_t e;
        e.led = led;
        e.irq = irq;
        if (sel) tq2.push_back(e);
        else     tq4.push_back(e);
    endfunction

    // Expected per-cycle LED trace of a whole walk starting the cycle after GO.
    function automatic void push_walk(input logic sel, input int n, input logic wrap,
                                      input int div, input int rep, input logic tail);
        int seq[$];
        int d;
        d = (div == 0) ? 1 : div;
        for (int p = 0; p < n; p++) seq.push_back(p);
        if (!wrap) for (int p = n - 2; p >= 0; p--) seq.push_back(p);
        for (int r = 0; r <= rep; r++)
            foreach (seq[i])
                for (int k = 0; k < d; k++) push_trace(sel, 32'd1 << seq[i], 1'b0);
        push_trace(sel, 32'd0, 1'b1);
        if (tail) push_trace(sel, 32'd0, 1'b0);
    endfunction

    // One bus request; returns the number of cycles it was stalled.
    task automatic wb_req(input logic sel, input logic w, input logic [1:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, output int stalls);
        int n;
        ack_t e;
        n = 0;
        @(negedge clk);
        cyc4 = !sel; cyc2 = sel; stb = 1'b1; we = w; addr = a; wdata = d;
        #1;
        while ((sel ? stall2 : stall4) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) check_eq("stall_bound", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        cyc4 = 1'b0; cyc2 = 1'b0; stb = 1'b0; we = 1'b0;
        e.sel = sel; e.is_rd = !w; e.data = exp_rd;
        aq.push_back(e);
        stalls = n;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((tq4.size() != 0 || tq2.size() != 0 || aq.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check_eq("drain_bound", 32'(n), 32'd0);
    endtask

    // Scoreboard monitor: pops expected LED/irq traces and bus responses.
    always @(negedge clk) begin
        trace_t t;
        ack_t   e;
        logic   exp4, exp2;
        if (!rst) begin
            exp4 = 1'b0;
            exp2 = 1'b0;
            if (tq4.size() != 0) begin
                t = tq4.pop_front();
                check_eq("led4", 32'(led4), t.led);
                check_eq("int4", 32'(int4), 32'(t.irq));
            end
            if (tq2.size() != 0) begin
                t = tq2.pop_front();
                check_eq("led2", 32'(led2), t.led);
                check_eq("int2", 32'(int2), 32'(t.irq));
            end
            if (aq.size() != 0) begin
                e = aq.pop_front();
                if (e.sel) exp2 = 1'b1;
                else       exp4 = 1'b1;
                if (e.is_rd) check_eq("rdata", e.sel ? data2 : data4, e.data);
            end
            check_eq("ack4", 32'(ack4), 32'(exp4));
            check_eq("ack2", 32'(ack2), 32'(exp2));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cyc4 = 1'b0; cyc2 = 1'b0; stb = 1'b0; we = 1'b0;
        addr = 2'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and register defaults.
        @(negedge clk);
        check_eq("rst_led4", 32'(led4), 32'd0);
        check_eq("rst_int4", 32'(int4), 32'd0);
        check_eq("rst_data4", data4, 32'd0);
        check_eq("rst_stall4", 32'(stall4), 32'd0);
        wb_req(1'b0, 1'b0, 2'd1, 32'd0, DDIV, st);
        wb_req(1'b0, 1'b0, 2'd2, 32'd0, 32'd0, st);
        wb_req(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, st);
        wb_req(1'b0, 1'b0, 2'd3, 32'd0, 32'd0, st);
        wb_req(1'b1, 1'b0, 2'd1, 32'd0, DDIV, st);
        // CTRL write without GO while idle changes nothing.
        wb_req(1'b0, 1'b1, 2'd0, 32'h2, 32'd0, st);
        wb_req(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, st);
        wait_idle();

        // Bounce, DIV=2, REP=0.
        wb_req(1'b0, 1'b1, 2'd1, 32'd2, 32'd0, st);
        wb_req(1'b0, 1'b1, 2'd2, 32'd0, 32'd0, st);
        wb_req(1'b0, 1'b1, 2'd0, 32'h1, 32'd0, st);
        push_walk(1'b0, 4, 1'b0, 2, 0, 1'b1);
        wb_req(1'b0, 1'b0, 2'd0, 32'd0, 32'h0000_0001, st);
        check_eq("rd_busy_nostall", 32'(st), 32'd0);
        wait_idle();

        // Wrap, DIV=3, REP=1; DIV rewritten mid-walk must not disturb it.
        wb_req(1'b0, 1'b1, 2'd1, 32'd3, 32'd0, st);
        wb_req(1'b0, 1'b1, 2'd2, 32'd1, 32'd0, st);
        wb_req(1'b0, 1'b1, 2'd0, 32'h3, 32'd0, st);
        push_walk(1'b0, 4, 1'b1, 3, 1, 1'b1);
        wb_req(1'b0, 1'b0, 2'd0, 32'd0, 32'h0001_0003, st);
        wb_req(1'b0, 1'b1, 2'd1, 32'd1, 32'd0, st);
        check_eq("div_wr_busy_nostall", 32'(st), 32'd0);
        wb_req(1'b0, 1'b0, 2'd3, 32'd0, 32'h0000_0001, st);
        wb_req(1'b0, 1'b0, 2'd0, 32'd0, 32'h0001_0103, st);
        wait_idle();
        wb_req(1'b0, 1'b0, 2'd1, 32'd0, 32'd1, st);
        wait_idle();

`ifdef WBLEDWALKER_ABORT_EN
        // Abort during the third step: LEDs off next cycle, no interrupt.
        wb_req(1'b0, 1'b1, 2'd1, 32'd2, 32'd0, st);
        wb_req(1'b0, 1'b1, 2'd2, 32'd2, 32'd0, st);
        wb_req(1'b0, 1'b1, 2'd0, 32'h1, 32'd0, st);
        push_trace(1'b0, 32'd1, 1'b0);
        push_trace(1'b0, 32'd1, 1'b0);
        push_trace(1'b0, 32'd2, 1'b0);
        push_trace(1'b0, 32'd2, 1'b0);
        push_trace(1'b0, 32'd4, 1'b0);
        push_trace(1'b0, 32'd0, 1'b0);
        push_trace(1'b0, 32'd0, 1'b0);
        push_trace(1'b0, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        wb_req(1'b0, 1'b1, 2'd0, 32'h4, 32'd0, st);
        check_eq("abort_nostall", 32'(st), 32'd0);
        wb_req(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, st);
        wait_idle();
`else
        // GO while busy stalls for the whole walk and is taken after completion.
        wb_req(1'b0, 1'b1, 2'd1, 32'd2, 32'd0, st);
        wb_req(1'b0, 1'b1, 2'd2, 32'd0, 32'd0, st);
        wb_req(1'b0, 1'b1, 2'd0, 32'h1, 32'd0, st);
        push_walk(1'b0, 4, 1'b0, 2, 0, 1'b0);
        wb_req(1'b0, 1'b1, 2'd0, 32'h1, 32'd0, st);
        check_eq("go_busy_stall_cycles", 32'(st), 32'd14);
        push_walk(1'b0, 4, 1'b0, 2, 0, 1'b1);
        wait_idle();
`endif

        // DIV=0 on the two-LED walker: three one-cycle steps.
        wb_req(1'b1, 1'b1, 2'd1, 32'd0, 32'd0, st);
        wb_req(1'b1, 1'b1, 2'd2, 32'd0, 32'd0, st);
        wb_req(1'b1, 1'b1, 2'd0, 32'h1, 32'd0, st);
        push_walk(1'b1, 2, 1'b0, 0, 0, 1'b1);
        wait_idle();
        wb_req(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, st);
        wait_idle();

        // Reset asserted mid-walk.
        wb_req(1'b0, 1'b1, 2'd1, 32'd2, 32'd0, st);
        wb_req(1'b0, 1'b1, 2'd2, 32'd3, 32'd0, st);
        wb_req(1'b0, 1'b1, 2'd0, 32'h1, 32'd0, st);
        push_trace(1'b0, 32'd1, 1'b0);
        push_trace(1'b0, 32'd1, 1'b0);
        push_trace(1'b0, 32'd2, 1'b0);
        repeat (3) @(negedge clk);
        we = 1'b1; addr = 2'd0;
        #1;
        check_eq("busy_stall_pre_rst", 32'(stall4), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_led4", 32'(led4), 32'd0);
        check_eq("midrst_int4", 32'(int4), 32'd0);
        check_eq("midrst_ack4", 32'(ack4), 32'd0);
        check_eq("midrst_data4", data4, 32'd0);
        check_eq("midrst_stall4", 32'(stall4), 32'd0);
        we = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        wb_req(1'b0, 1'b0, 2'd1, 32'd0, DDIV, st);
        wb_req(1'b0, 1'b0, 2'd2, 32'd0, 32'd0, st);
        wb_req(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, st);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
